// File: rtl/itlb_cam_array_if.sv
// Lookup, refill and flush ports of the ITLB CAM array.
// The master side is the IF stage / page-table walker; the slave side is the array.
interface itlb_cam_array_if #(
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  parameter int PPN_WD  = 22
);
  logic                       lkp_valid_i;
  logic [ASID_WD-1:0]         lkp_asid_i;
  logic [VPN1_WD+VPN0_WD-1:0] lkp_vpn_i;
  logic                       lkp_valid_o;
  logic                       lkp_hit_o;
  logic [PPN_WD-1:0]          lkp_ppn_o;
  logic [1:0]                 lkp_perm_o;

  logic                       refill_valid_i;
  logic                       refill_ready_o;
  logic [ASID_WD-1:0]         refill_asid_i;
  logic [VPN1_WD+VPN0_WD-1:0] refill_vpn_i;
  logic [PPN_WD-1:0]          refill_ppn_i;
  logic                       refill_g_i;
  logic                       refill_super_i;
  logic [1:0]                 refill_perm_i;

  logic                       flush_valid_i;
  logic                       flush_asid_en_i;
  logic [ASID_WD-1:0]         flush_asid_i;
  logic                       flush_vpn_en_i;
  logic [VPN1_WD+VPN0_WD-1:0] flush_vpn_i;

  modport master (
    output lkp_valid_i, lkp_asid_i, lkp_vpn_i,
    input  lkp_valid_o, lkp_hit_o, lkp_ppn_o, lkp_perm_o,
    output refill_valid_i, refill_asid_i, refill_vpn_i, refill_ppn_i,
    output refill_g_i, refill_super_i, refill_perm_i,
    input  refill_ready_o,
    output flush_valid_i, flush_asid_en_i, flush_asid_i, flush_vpn_en_i, flush_vpn_i
  );

  modport slave (
    input  lkp_valid_i, lkp_asid_i, lkp_vpn_i,
    output lkp_valid_o, lkp_hit_o, lkp_ppn_o, lkp_perm_o,
    input  refill_valid_i, refill_asid_i, refill_vpn_i, refill_ppn_i,
    input  refill_g_i, refill_super_i, refill_perm_i,
    output refill_ready_o,
    input  flush_valid_i, flush_asid_en_i, flush_asid_i, flush_vpn_en_i, flush_vpn_i
  );
endinterface

// File: rtl/itlb_cam_array.sv
// Fully-associative instruction TLB: per-entry CAM line plus the array top with
// registered lookup, duplicate-aware refill with round-robin victim, and selective flush.
module itlb_cam_entry #(
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  parameter int PPN_WD  = 22
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [ASID_WD-1:0]         lkp_asid,
  input  logic [VPN1_WD+VPN0_WD-1:0] lkp_vpn,
  input  logic [ASID_WD-1:0]         rf_asid,
  input  logic [VPN1_WD+VPN0_WD-1:0] rf_vpn,
  input  logic [PPN_WD-1:0]          rf_ppn,
  input  logic                       rf_g,
  input  logic                       rf_super,
  input  logic [1:0]                 rf_perm,
  input  logic                       flush,
  input  logic                       flush_asid_en,
  input  logic [ASID_WD-1:0]         flush_asid,
  input  logic                       flush_vpn_en,
  input  logic [VPN1_WD+VPN0_WD-1:0] flush_vpn,
  input  logic                       wr_en,
  input  logic                       inv_en,
  output logic                       valid,
  output logic                       lkp_match,
  output logic                       rf_match,
  output logic                       super_pg,
  output logic [PPN_WD-1:0]          ppn,
  output logic [1:0]                 perm
);
  localparam int VPN_WD = VPN1_WD + VPN0_WD;

  logic               v_q, g_q, s_q;
  logic [ASID_WD-1:0] asid_q;
  logic [VPN1_WD-1:0] vpn1_q;
  logic [VPN0_WD-1:0] vpn0_q;
  logic [PPN_WD-1:0]  ppn_q;
  logic [1:0]         perm_q;
  logic               flush_hit;

  assign lkp_match = v_q & (g_q | (asid_q == lkp_asid))
                   & (vpn1_q == lkp_vpn[VPN_WD-1:VPN0_WD])
                   & (s_q | (vpn0_q == lkp_vpn[VPN0_WD-1:0]));

  // An incoming superpage also covers any 4K page under the same vpn1.
  assign rf_match  = v_q & (g_q | (asid_q == rf_asid))
                   & (vpn1_q == rf_vpn[VPN_WD-1:VPN0_WD])
                   & (s_q | rf_super | (vpn0_q == rf_vpn[VPN0_WD-1:0]));

  // Each enabled qualifier must hold; ASID qualification spares global pages.
  assign flush_hit = (~flush_asid_en | (~g_q & (asid_q == flush_asid)))
                   & (~flush_vpn_en  | ((vpn1_q == flush_vpn[VPN_WD-1:VPN0_WD])
                                      & (s_q | (vpn0_q == flush_vpn[VPN0_WD-1:0]))));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  v_q <= 1'b0;
    else if (flush & flush_hit) v_q <= 1'b0;
    else if (wr_en)             v_q <= 1'b1;
    else if (inv_en)            v_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      g_q    <= rf_g;
      s_q    <= rf_super;
      asid_q <= rf_asid;
      vpn1_q <= rf_vpn[VPN_WD-1:VPN0_WD];
      vpn0_q <= rf_vpn[VPN0_WD-1:0];
      ppn_q  <= rf_ppn;
      perm_q <= rf_perm;
    end
  end

  assign valid    = v_q;
  assign super_pg = s_q;
  assign ppn      = ppn_q;
  assign perm     = perm_q;
endmodule

module itlb_cam_array #(
  parameter int ENTRIES = 8,
  parameter int ASID_WD = 9,
  parameter int VPN1_WD = 10,
  parameter int VPN0_WD = 10,
  parameter int PPN_WD  = 22
) (
  input logic            clk_i,
  input logic            rst_i,
  itlb_cam_array_if.slave bus
);
  localparam int IW     = $clog2(ENTRIES);
  localparam int STAGES = 1;

  typedef struct packed {
    logic              hit;
    logic [PPN_WD-1:0] ppn;
    logic [1:0]        perm;
  } lkp_rsp_t;

  logic [ENTRIES-1:0]             ent_valid, ent_lkp_match, ent_rf_match, ent_super;
  logic [ENTRIES-1:0][PPN_WD-1:0] ent_ppn;
  logic [ENTRIES-1:0][1:0]        ent_perm;
  logic [ENTRIES-1:0]             wr_en, inv_en, rf_sel, lkp_oh, rr_oh;
  logic [IW-1:0]                  rr_q;
  logic                           rf_acc, rf_any, full, rr_adv;
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:1]                vld_q;
  lkp_rsp_t                       rsp_d, rsp_q;

  function automatic logic [ENTRIES-1:0] lowest(input logic [ENTRIES-1:0] v);
    return v & (~v + ENTRIES'(1));
  endfunction

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    itlb_cam_entry #(
      .ASID_WD(ASID_WD), .VPN1_WD(VPN1_WD), .VPN0_WD(VPN0_WD), .PPN_WD(PPN_WD)
    ) u_ent (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .lkp_asid      (bus.lkp_asid_i),
      .lkp_vpn       (bus.lkp_vpn_i),
      .rf_asid       (bus.refill_asid_i),
      .rf_vpn        (bus.refill_vpn_i),
      .rf_ppn        (bus.refill_ppn_i),
      .rf_g          (bus.refill_g_i),
      .rf_super      (bus.refill_super_i),
      .rf_perm       (bus.refill_perm_i),
      .flush         (bus.flush_valid_i),
      .flush_asid_en (bus.flush_asid_en_i),
      .flush_asid    (bus.flush_asid_i),
      .flush_vpn_en  (bus.flush_vpn_en_i),
      .flush_vpn     (bus.flush_vpn_i),
      .wr_en         (wr_en[i]),
      .inv_en        (inv_en[i]),
      .valid         (ent_valid[i]),
      .lkp_match     (ent_lkp_match[i]),
      .rf_match      (ent_rf_match[i]),
      .super_pg      (ent_super[i]),
      .ppn           (ent_ppn[i]),
      .perm          (ent_perm[i])
    );
  end

  // Refill: overwrite a duplicate, else first free line, else round-robin victim.
  assign bus.refill_ready_o = ~bus.flush_valid_i;
  assign rf_acc = bus.refill_valid_i & ~bus.flush_valid_i;
  assign rf_any = |ent_rf_match;
  assign full   = &ent_valid;
  assign rr_oh  = ENTRIES'(1) << rr_q;
  assign rr_adv = rf_acc & ~rf_any & full;

  always_comb begin
    rf_sel = rr_oh;
    if (rf_any)     rf_sel = lowest(ent_rf_match);
    else if (!full) rf_sel = lowest(~ent_valid);
  end

  assign wr_en  = {ENTRIES{rf_acc}} & rf_sel;
  assign inv_en = {ENTRIES{rf_acc}} & ent_rf_match & ~rf_sel;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       rr_q <= '0;
    else if (rr_adv) rr_q <= rr_q + IW'(1);
  end

  // Lookup: lowest matching line wins; superpages splice vpn0 into the PPN.
  assign lkp_oh = lowest(ent_lkp_match);

  always_comb begin
    rsp_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (lkp_oh[i]) begin
        rsp_d.hit  = 1'b1;
        rsp_d.perm = ent_perm[i];
        rsp_d.ppn  = ent_super[i]
                   ? {ent_ppn[i][PPN_WD-1:VPN0_WD], bus.lkp_vpn_i[VPN0_WD-1:0]}
                   : ent_ppn[i];
      end
    end
    if (!bus.lkp_valid_i) rsp_d = '0;
  end

  assign vld_pipe = {vld_q, bus.lkp_valid_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      rsp_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      rsp_q <= rsp_d;
    end
  end

  assign bus.lkp_valid_o = vld_pipe[STAGES];
  assign bus.lkp_hit_o   = rsp_q.hit;
  assign bus.lkp_ppn_o   = rsp_q.ppn;
  assign bus.lkp_perm_o  = rsp_q.perm;
endmodule

// File: doc/itlb_cam_array.md
# itlb_cam_array

Parametrised, fully-associative instruction TLB array: ENTRIES CAM lines with per-entry ASID, global bit, superpage flag, PPN and permissions. It provides a registered single-cycle lookup, a refill port with duplicate-overwrite and round-robin victim selection, and sfence.vma-style selective flush by ASID and/or VPN. It sits between the IF stage (lookup) and the page-table walker (refill) in the MMS.

## Interface
Parameters:
- ENTRIES, 8: number of CAM lines; power of two, ≥2.
- ASID_WD, 9: ASID width.
- VPN1_WD, 10: upper VPN field width.
- VPN0_WD, 10: lower VPN field width.
- PPN_WD, 22: physical page number width; must be > VPN0_WD.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- lkp_valid_i  in  1  lookup request.
- lkp_asid_i  in  ASID_WD  lookup ASID.
- lkp_vpn_i  in  VPN1_WD+VPN0_WD  lookup VPN as {vpn1, vpn0}.
- lkp_valid_o  out  1  lookup result valid, one cycle after lkp_valid_i.
- lkp_hit_o  out  1  lookup hit.
- lkp_ppn_o  out  PPN_WD  translated PPN.
- lkp_perm_o  out  2  {u, x} of the hit entry.
- refill_valid_i  in  1  refill request.
- refill_ready_o  out  1  refill accepted this cycle.
- refill_asid_i  in  ASID_WD  refill ASID.
- refill_vpn_i  in  VPN1_WD+VPN0_WD  refill VPN.
- refill_ppn_i  in  PPN_WD  refill PPN.
- refill_g_i  in  1  global page.
- refill_super_i  in  1  superpage (VPN0 ignored in matching).
- refill_perm_i  in  2  {u, x}.
- flush_valid_i  in  1  flush request, single cycle.
- flush_asid_en_i  in  1  qualify flush by ASID.
- flush_asid_i  in  ASID_WD  flush ASID.
- flush_vpn_en_i  in  1  qualify flush by VPN.
- flush_vpn_i  in  VPN1_WD+VPN0_WD  flush VPN.

## Operation
- Entry match(asid, vpn): valid & (g | asid_q == asid) & vpn1_q == vpn1 & (super_q | vpn0_q == vpn0).
- Lookup: the match vector is computed against array state before the clock edge. Results are registered. Hit PPN is ppn_q for 4K pages and {ppn_q[PPN_WD-1:VPN0_WD], lkp_vpn_i.vpn0} for superpages. On a miss, lkp_ppn_o and lkp_perm_o are 0. If multiple entries match, the lowest index wins.
- Refill: refill_ready_o = ~flush_valid_i, combinational. The write happens on the edge where refill_valid_i & refill_ready_o.
  - If any entry matches (refill ASID/VPN, with refill_super_i also forcing VPN0 don't-care), the lowest-index matching entry is overwritten and all other matching entries are invalidated.
  - Else, if any entry is invalid, the lowest-index invalid entry is written.
  - Else, entry rr_q is written and rr_q increments modulo ENTRIES, wrapping ENTRIES-1 to 0. Only this case advances rr_q.
- Flush: one edge, with priority over refill.
  - asid_en=0, vpn_en=0: all entries are invalidated, including global entries.
  - asid_en=1: entries with asid_q == flush_asid_i and g=0 are invalidated.
  - vpn_en=1: entries whose VPN matches flush_vpn_i are invalidated, with superpage entries ignoring VPN0. The g bit is ignored.
  - Both enables set: both conditions must hold, and only g=0 entries are invalidated.
- Flush does not reset rr_q.

## Timing
- Reset values: all valid bits 0, rr_q 0, lkp_valid_o 0, lkp_hit_o 0, lkp_ppn_o 0, lkp_perm_o 0. refill_ready_o follows flush_valid_i during reset. Reset asserted mid-lookup discards that result.
- Lookup latency is 1 cycle. lkp_valid_o = registered lkp_valid_i. When lkp_valid_i=0, the hit/ppn/perm registers load 0.
- Lookup in the same cycle as a refill or flush returns the pre-edge state. The refilled entry is visible to a lookup issued on the next cycle.
- The array is fully pipelined: one lookup per cycle, back-to-back.

## Test plan
- Reset; lookup asid=2, vpn=0x4FF → next cycle lkp_valid_o=1, hit=0, ppn=0.
- Refill asid=2, vpn=0x004FF, ppn=0x12345, g=0, 4K; the next-cycle lookup with asid=2 → hit, ppn=0x12345. Lookup with asid=3 → miss. Refill the same VPN with g=1, then lookup with asid=3 → hit.
- Refill superpage vpn1=0x001, ppn=0x3FC00; lookup vpn={0x001, 0x2A5} → hit, ppn=0x3FEA5.
- Fill all 8 entries, then refill 3 new VPNs → entries 0, 1, 2 are replaced and rr_q=3. Fill past 8 more replacements → rr_q wraps to 3 again. Refill of an existing VPN does not advance rr_q.
- Flush asid_en=1, asid=2 with one global and one non-global ASID-2 entry → only the non-global entry misses afterwards. Flush with both enables clear → all entries miss.
- Assert refill and flush in the same cycle → refill_ready_o=0, no entry written. Lookup in the same cycle as the flush → hit reported on the pre-flush entry; lookup one cycle later → miss.
